// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Each digit owns a slot of CLK_DIV cycles. The first BLANK_CYC cycles of a
// slot keep every anode off so the previous digit's segments cannot ghost.
// Shadow registers are reloaded only on a frame boundary, or at once while
// the display is off, so a frame never mixes old and new digits.
// Optional leading-zero suppression blanks high-order zero digits.
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        dp_out,
    output logic        frame_done
);

    localparam int             CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // A digit is blanked when suppression is on, it is not digit0, and it
    // and every digit above it hold zero.
    function automatic logic digit_suppressed(input logic [1:0]  idx,
                                              input logic [15:0] nib,
                                              input logic        lz);
        logic [15:0] upper;
        upper = nib >> {idx, 2'b00};
        return lz && (idx != 2'd0) && (upper == 16'h0000);
    endfunction

    // Pick one BCD nibble out of the packed shadow word.
    function automatic logic [3:0] nibble_at(input logic [15:0] nib,
                                             input logic [1:0]  idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = nib[3:0];
            2'd1:    r = nib[7:4];
            2'd2:    r = nib[11:8];
            2'd3:    r = nib[15:12];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   shadow_data_q, shadow_data_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dp_out_q, dp_out_d;
    logic          upd_ack_q, upd_ack_d;
    logic          frame_done_q, frame_done_d;
    logic          scanning_s;
    logic          boundary_s;
    logic          load_s;
    logic          lit_s;

    // Next-state logic: slot sequencing, shadow loading and output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;

        scanning_s = (state_q != ST_OFF);
        // Last cycle of digit3's slot with scanning continuing: the wrap edge.
        boundary_s = scanning_s && en && (cnt_q == CNT_MAX) && (sel_q == 2'd3);
        // The cycle carrying the ack still sees the old request level, so it
        // must not trigger a second load.
        load_s     = upd_req && !upd_ack_q && (!scanning_s || boundary_s);

        if (load_s) begin
            shadow_data_d = data_in;
            shadow_dp_d   = dp_in;
        end else begin
            shadow_data_d = shadow_data_q;
            shadow_dp_d   = shadow_dp_q;
        end

        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                sel_d = 2'd0;
                if (en) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_BLANK, ST_SHOW: begin
                if (!en) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    sel_d   = sel_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if ((cnt_q + CW'(1)) >= BLANK_END) begin
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
                sel_d   = 2'd0;
            end
        endcase

        lit_s = (state_d == ST_SHOW) && !digit_suppressed(sel_d, shadow_data_d, lz_en);

        if (lit_s) begin
            an_d     = ~(4'b0001 << sel_d);
            dp_out_d = ~shadow_dp_d[sel_d];
        end else begin
            an_d     = 4'b1111;
            dp_out_d = 1'b1;
        end

        bcd_d        = nibble_at(shadow_data_d, sel_d);
        upd_ack_d    = load_s;
        frame_done_d = boundary_s;
    end

    // State, shadow and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_OFF;
            cnt_q         <= '0;
            sel_q         <= 2'd0;
            shadow_data_q <= 16'h0000;
            shadow_dp_q   <= 4'h0;
            an_q          <= 4'b1111;
            bcd_q         <= 4'h0;
            dp_out_q      <= 1'b1;
            upd_ack_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            an_q          <= an_d;
            bcd_q         <= bcd_d;
            dp_out_q      <= dp_out_d;
            upd_ack_q     <= upd_ack_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign digit_sel  = sel_q;
    assign bcd_out    = bcd_q;
    assign dp_out     = dp_out_q;
    assign upd_ack    = upd_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
// The reference model tracks only "display on" and a 0..31 position within the
// frame; all outputs are derived arithmetically from that position.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        lz_en = 1'b0;
    logic        upd_req = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        upd_ack;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .dp_in(dp_in),
        .lz_en(lz_en), .upd_req(upd_req), .upd_ack(upd_ack), .an(an),
        .digit_sel(digit_sel), .bcd_out(bcd_out), .dp_out(dp_out),
        .frame_done(frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_on;
    int          m_pos;
    logic [15:0] m_sh;
    logic [3:0]  m_dp;
    bit          m_ack, m_fd, m_lz;
    bit          m_bnd, m_ld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on = 0; m_pos = 0; m_sh = 16'h0000; m_dp = 4'h0;
            m_ack = 0; m_fd = 0; m_lz = 0;
        end else begin
            m_bnd = m_on && en && (m_pos == 31);
            m_ld  = upd_req && !m_ack && (!m_on || m_bnd);
            if (m_ld) begin
                m_sh = data_in;
                m_dp = dp_in;
            end
            m_ack = m_ld;
            m_fd  = m_bnd;
            m_lz  = lz_en;
            if (!m_on) begin
                m_on  = en;
                m_pos = 0;
            end else if (!en) begin
                m_on  = 0;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % 32;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        int d;
        bit lit;
        logic [15:0] upper;
        logic [3:0]  e_an;
        logic        e_dp;
        d     = m_pos / 8;
        upper = m_sh >> (4 * d);
        lit   = m_on && ((m_pos % 8) >= 2) && !(m_lz && d != 0 && upper == 16'h0000);
        e_an  = lit ? ~(4'b0001 << d) : 4'b1111;
        e_dp  = lit ? ~m_dp[d] : 1'b1;
        chk("an",         {12'h000, an},             {12'h000, e_an});
        chk("digit_sel",  {14'h0000, digit_sel},     16'(d));
        chk("bcd_out",    {12'h000, bcd_out},        {12'h000, upper[3:0]});
        chk("dp_out",     {15'h0000, dp_out},        {15'h0000, e_dp});
        chk("upd_ack",    {15'h0000, upd_ack},       {15'h0000, m_ack});
        chk("frame_done", {15'h0000, frame_done},    {15'h0000, m_fd});
    end

    // Wait (bounded) for upd_ack at a falling edge; flag a timeout as a failure.
    task automatic wait_ack(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (upd_ack) seen = 1;
        end
        chk({nm, "_ack_seen"}, {15'h0000, seen}, 16'h0001);
    endtask

    // Wait (bounded) for a given digit slot.
    task automatic wait_sel(input logic [1:0] s, input bit need_lit, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (digit_sel == s && (!need_lit || an != 4'b1111)) seen = 1;
        end
        chk({nm, "_slot_seen"}, {15'h0000, seen}, 16'h0001);
    endtask

    // Issue one update and hold it until acknowledged.
    task automatic do_update(input logic [15:0] d, input logic [3:0] p, input string nm);
        data_in = d; dp_in = p; upd_req = 1'b1;
        wait_ack(nm);
        upd_req = 1'b0;
    endtask

    int fd_t[$];
    int lit_n, e_only, dp_n, dp_other;
    int mask_sel;
    logic [15:0] masks [5];

    initial begin
        masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
        masks[3] = 16'h000F; masks[4] = 16'h0000;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_an",  {12'h000, an}, 16'h000F);
        chk("rst_dp",  {15'h0000, dp_out}, 16'h0001);
        chk("rst_bcd", {12'h000, bcd_out}, 16'h0000);

        // 1: free scan with zero shadow.
        en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 1) chk("t1_blank", {12'h000, an}, 16'h000F);
            if (i == 2) chk("t1_show0", {12'h000, an}, 16'h000E);
            if (i == 10) chk("t1_show1", {12'h000, an}, 16'h000D);
            if (frame_done) fd_t.push_back(i);
        end
        chk("t1_fd_count", 16'(fd_t.size()), 16'd2);
        if (fd_t.size() >= 2) chk("t1_fd_period", 16'(fd_t[1] - fd_t[0]), 16'd32);

        // 2: update raised during digit1 is held off until the wrap.
        wait_sel(2'd1, 1'b0, "t2");
        data_in = 16'h1234; dp_in = 4'h0; upd_req = 1'b1;
        wait_ack("t2");
        chk("t2_ack_sel", {14'h0000, digit_sel}, 16'h0000);
        chk("t2_ack_bcd", {12'h000, bcd_out}, 16'h0004);
        upd_req = 1'b0;
        wait_sel(2'd3, 1'b0, "t2b");
        chk("t2_bcd3", {12'h000, bcd_out}, 16'h0001);

        // 3: leading-zero suppression.
        lz_en = 1'b1;
        do_update(16'h0040, 4'h0, "t3a");
        lit_n = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an != 4'b1111) lit_n++;
        end
        chk("t3_lit_0040", 16'(lit_n), 16'd12);
        do_update(16'h0000, 4'h0, "t3b");
        lit_n = 0; e_only = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an != 4'b1111) lit_n++;
            if (an != 4'b1111 && an != 4'b1110) e_only++;
        end
        chk("t3_lit_0000", 16'(lit_n), 16'd6);
        chk("t3_only_d0",  16'(e_only), 16'd0);
        lz_en = 1'b0;

        // 4: decimal point on digit1 only, SHOW portion only.
        do_update(16'h1234, 4'b0010, "t4");
        dp_n = 0; dp_other = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!dp_out) dp_n++;
            if (!dp_out && (digit_sel != 2'd1 || an == 4'b1111)) dp_other++;
        end
        chk("t4_dp_cycles", 16'(dp_n), 16'd6);
        chk("t4_dp_other",  16'(dp_other), 16'd0);

        // 5: disable mid-frame, update while off, re-enable.
        wait_sel(2'd2, 1'b1, "t5");
        en = 1'b0;
        @(negedge clk);
        chk("t5_an_off", {12'h000, an}, 16'h000F);
        chk("t5_sel0",   {14'h0000, digit_sel}, 16'h0000);
        chk("t5_no_fd",  {15'h0000, frame_done}, 16'h0000);
        data_in = 16'h5678; dp_in = 4'h0; upd_req = 1'b1;
        @(negedge clk);
        chk("t5_ack_fast", {15'h0000, upd_ack}, 16'h0001);
        upd_req = 1'b0;
        en = 1'b1;
        wait_sel(2'd0, 1'b1, "t5b");
        chk("t5_bcd8", {12'h000, bcd_out}, 16'h0008);

        // 6: async reset mid-SHOW drops the pending request.
        wait_sel(2'd1, 1'b1, "t6");
        data_in = 16'h9999; upd_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_an_async", {12'h000, an}, 16'h000F);
        chk("t6_dp_async", {15'h0000, dp_out}, 16'h0001);
        @(negedge clk);
        upd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        data_in = 16'h4321; dp_in = 4'h0; upd_req = 1'b1;
        wait_ack("t6");
        chk("t6_ack_sel", {14'h0000, digit_sel}, 16'h0000);
        chk("t6_ack_bcd", {12'h000, bcd_out}, 16'h0001);
        upd_req = 1'b0;

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (upd_ack) begin
                upd_req = 1'b0;
            end else if (!upd_req && ($urandom % 8) == 0) begin
                mask_sel = $urandom % 5;
                data_in  = 16'($urandom) & masks[mask_sel];
                dp_in    = 4'($urandom);
                upd_req  = 1'b1;
            end
            if (en && ($urandom % 200) == 0) en = 1'b0;
            else if (!en && ($urandom % 10) == 0) en = 1'b1;
            if (($urandom % 50) == 0) lz_en = ~lz_en;
            if (($urandom % 700) == 0) begin
                upd_req = 1'b0;
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
